btn_debounce_array: RTL and testbench

//  Per-button input conditioner: the stage directly upstream of the maze game logic.

---
 rtl/btn_debounce_array.sv | 154 +++++++++++++++
 tb/tb_btn_debounce_array.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_array.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_array
//  Description : Per-button input conditioner for the maze game. Each raw
//                push-button is synchronised, debounced and turned into four
//                enables: a debounced level, a single-clock press pulse, an
//                auto-repeating press pulse and a continuous held enable.
//  Ports       : clk      - system clock, all logic on the rising edge
//                reset    - synchronous, active-high
//                buttons  - raw asynchronous button levels, 1 = pressed
//                DPBs     - debounced pressed level
//                SCENs    - one-cycle pulse per debounced press
//                MCENs    - pulse on press, then auto-repeat while held
//                CCENs    - high every cycle the button is held (not releasing)
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce_array #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MCEN_FIRST      = 50_000_000,
    parameter int MCEN_REPEAT     = 10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] buttons,
    output logic [N_BTN-1:0] DPBs,
    output logic [N_BTN-1:0] SCENs,
    output logic [N_BTN-1:0] MCENs,
    output logic [N_BTN-1:0] CCENs
);

    localparam int c_MAX_AB  = (DEBOUNCE_CYCLES > MCEN_FIRST) ? DEBOUNCE_CYCLES : MCEN_FIRST;
    localparam int c_MAX_CYC = (c_MAX_AB > MCEN_REPEAT) ? c_MAX_AB : MCEN_REPEAT;
    localparam int TIMER_W   = $clog2(c_MAX_CYC) + 1;

    // Timer compare values: a phase of N cycles ends when the timer reads N-1.
    localparam logic [TIMER_W-1:0] c_DEB_LAST    = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_FIRST_LAST  = TIMER_W'(MCEN_FIRST - 1);
    localparam logic [TIMER_W-1:0] c_REPEAT_LAST = TIMER_W'(MCEN_REPEAT - 1);
    localparam logic [TIMER_W-1:0] c_TIMER_ONE   = TIMER_W'(1);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_DEB_PRESS   = 3'd1;
    localparam logic [2:0] c_SCEN_PULSE  = 3'd2;
    localparam logic [2:0] c_HELD        = 3'd3;
    localparam logic [2:0] c_MCEN_PULSE  = 3'd4;
    localparam logic [2:0] c_DEB_RELEASE = 3'd5;

    // Two-flop synchroniser; r_sync2 is the only copy of the buttons the
    // state machines ever look at.
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        logic [2:0]         r_state;
        logic [TIMER_W-1:0] r_timer;
        logic               r_first;
        logic               w_btn_s;
        logic [TIMER_W-1:0] w_hold_last;

        assign w_btn_s     = r_sync2[gi];
        // The first repeat after a press waits longer than the later ones.
        assign w_hold_last = r_first ? c_FIRST_LAST : c_REPEAT_LAST;

        // The timer is cleared on every state change and only advances while
        // below its compare value, so it can never wrap.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_IDLE;
                r_timer <= '0;
                r_first <= 1'b1;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_btn_s) begin
                            r_state <= c_DEB_PRESS;
                            r_timer <= '0;
                        end
                    end
                    c_DEB_PRESS: begin
                        if (!w_btn_s) begin
                            r_state <= c_IDLE;
                            r_timer <= '0;
                        end else if (r_timer == c_DEB_LAST) begin
                            r_state <= c_SCEN_PULSE;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + c_TIMER_ONE;
                        end
                    end
                    c_SCEN_PULSE: begin
                        r_state <= c_HELD;
                        r_timer <= '0;
                        r_first <= 1'b1;
                    end
                    c_HELD: begin
                        if (!w_btn_s) begin
                            r_state <= c_DEB_RELEASE;
                            r_timer <= '0;
                        end else if (r_timer == w_hold_last) begin
                            r_state <= c_MCEN_PULSE;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + c_TIMER_ONE;
                        end
                    end
                    c_MCEN_PULSE: begin
                        r_state <= c_HELD;
                        r_timer <= '0;
                        r_first <= 1'b0;
                    end
                    c_DEB_RELEASE: begin
                        // A bounce back to pressed resumes holding but keeps
                        // the first/repeat selection as it was.
                        if (w_btn_s) begin
                            r_state <= c_HELD;
                            r_timer <= '0;
                        end else if (r_timer == c_DEB_LAST) begin
                            r_state <= c_IDLE;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + c_TIMER_ONE;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_timer <= '0;
                        r_first <= 1'b1;
                    end
                endcase
            end
        end

        // Moore decodes of the state register only.
        assign DPBs[gi]  = (r_state == c_SCEN_PULSE) || (r_state == c_HELD) ||
                           (r_state == c_MCEN_PULSE) || (r_state == c_DEB_RELEASE);
        assign SCENs[gi] = (r_state == c_SCEN_PULSE);
        assign MCENs[gi] = (r_state == c_SCEN_PULSE) || (r_state == c_MCEN_PULSE);
        assign CCENs[gi] = (r_state == c_SCEN_PULSE) || (r_state == c_HELD) ||
                           (r_state == c_MCEN_PULSE);
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce_array
//  Description : Self-checking bench for btn_debounce_array. Directed vector
//                table and corner-case sequences, then randomised buttons
//                compared every cycle against a run-length reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_debounce_array;

    localparam int c_D  = 4;
    localparam int c_MF = 8;
    localparam int c_MR = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic [3:0] DPBs, SCENs, MCENs, CCENs;

    int n_checks = 0;
    int n_errors = 0;

    btn_debounce_array #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (c_D),
        .MCEN_FIRST      (c_MF),
        .MCEN_REPEAT     (c_MR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons),
        .DPBs    (DPBs),
        .SCENs   (SCENs),
        .MCENs   (MCENs),
        .CCENs   (CCENs)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // A press is accepted after D+1 consecutive high synchronised samples; a
    // release after D+1 consecutive low samples. Samples coinciding with an
    // output pulse are ignored. While held, a repeat fires after MF (then MR)
    // consecutive high samples; any bounce back restarts that count.
    bit m_h1[4], m_h2[4];
    bit m_pressed[4], m_scen[4], m_mcen[4], m_first[4];
    int m_ones[4], m_zeros[4], m_hold[4];

    task automatic model_edge(input logic [3:0] raw, input logic rst);
        bit s;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_h1[i] = 0; m_h2[i] = 0;
                m_pressed[i] = 0; m_scen[i] = 0; m_mcen[i] = 0; m_first[i] = 1;
                m_ones[i] = 0; m_zeros[i] = 0; m_hold[i] = 0;
            end else begin
                s = m_h2[i];
                m_h2[i] = m_h1[i];
                m_h1[i] = raw[i];
                if (!m_pressed[i]) begin
                    m_ones[i] = s ? m_ones[i] + 1 : 0;
                    if (m_ones[i] == c_D + 1) begin
                        m_pressed[i] = 1; m_scen[i] = 1; m_mcen[i] = 1;
                        m_first[i] = 1; m_ones[i] = 0; m_hold[i] = 0; m_zeros[i] = 0;
                    end
                end else if (m_mcen[i]) begin
                    m_scen[i] = 0; m_mcen[i] = 0; m_hold[i] = 0;
                end else if (!s) begin
                    m_zeros[i]++;
                    if (m_zeros[i] == c_D + 1) begin
                        m_pressed[i] = 0; m_zeros[i] = 0; m_ones[i] = 0;
                    end
                end else if (m_zeros[i] > 0) begin
                    m_zeros[i] = 0; m_hold[i] = 0;
                end else begin
                    m_hold[i]++;
                    if (m_hold[i] == (m_first[i] ? c_MF : c_MR)) begin
                        m_mcen[i] = 1; m_first[i] = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b required %b", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {3'b000, act}, {3'b000, exp});
    endtask

    // One clock: drive, let the edge happen, update model, sample 1ns later.
    task automatic step(input logic [3:0] b, input logic r);
        logic [3:0] e_dpb, e_scen, e_mcen, e_ccen;
        buttons = b;
        reset   = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        for (int i = 0; i < 4; i++) begin
            e_dpb[i]  = m_pressed[i];
            e_scen[i] = m_scen[i];
            e_mcen[i] = m_mcen[i];
            e_ccen[i] = m_pressed[i] && (m_zeros[i] == 0);
        end
        chk("model_dpb", DPBs, e_dpb);
        chk("model_scen", SCENs, e_scen);
        chk("model_mcen", MCENs, e_mcen);
        chk("model_ccen", CCENs, e_ccen);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0000, 1'b0);
    endtask

    typedef struct {
        logic [3:0] btn;
        logic [3:0] dpb;
        logic [3:0] scen;
        logic [3:0] mcen;
        logic [3:0] ccen;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [3:0] b;
        int         scen_cnt;
        int         slow;

        // Clean press on bit 0: SCEN/MCEN/DPB/CCEN all rise after E6.
        for (int k = 0; k < 6; k++) tbl[k] = '{4'b0001, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        tbl[7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};

        buttons = 4'b0000;
        reset   = 1'b1;
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("reset_state", DPBs | SCENs | MCENs | CCENs, 4'b0000);

        // ---- table-driven clean press ----
        for (int k = 0; k < 8; k++) begin
            step(tbl[k].btn, 1'b0);
            chk("tbl_dpb", DPBs, tbl[k].dpb);
            chk("tbl_scen", SCENs, tbl[k].scen);
            chk("tbl_mcen", MCENs, tbl[k].mcen);
            chk("tbl_ccen", CCENs, tbl[k].ccen);
        end
        idle(12);

        // ---- bounce on bit 1: never accepted ----
        for (int k = 0; k < 17; k++) begin
            b = ((k < 3) || (k == 4) || (k == 5)) ? 4'b0010 : 4'b0000;
            step(b, 1'b0);
            chk("bounce_quiet", DPBs | SCENs | MCENs | CCENs, 4'b0000);
        end

        // ---- hold repeat on bit 2 ----
        scen_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(4'b0100, 1'b0);
            if (SCENs[2]) scen_cnt++;
            chk1("hold_scen", SCENs[2], k == 6);
            chk1("hold_mcen", MCENs[2], (k == 6) || (k >= 15 && ((k - 15) % 4) == 0));
            chk1("hold_ccen", CCENs[2], k >= 6);
        end
        chk("hold_scen_count", 4'(scen_cnt), 4'd1);

        // ---- release of bit 2 ----
        for (int r = 0; r < 8; r++) begin
            step(4'b0000, 1'b0);
            chk1("release_ccen", CCENs[2], r < 2);
            chk1("release_dpb", DPBs[2], r < 6);
        end
        idle(8);

        // ---- short release glitch on bit 1 ----
        for (int k = 0; k < 10; k++) begin
            step(4'b0010, 1'b0);
            chk1("glitch_press_scen", SCENs[1], k == 6);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(4'b0010, 1'b0);
            chk1("glitch_dpb", DPBs[1], 1'b1);
            chk1("glitch_scen", SCENs[1], 1'b0);
        end
        idle(12);

        // ---- concurrent press, reset mid-hold, re-debounce ----
        for (int k = 0; k < 10; k++) begin
            step(4'b1111, 1'b0);
            chk("conc_scen", SCENs, (k == 6) ? 4'b1111 : 4'b0000);
        end
        step(4'b1111, 1'b1);
        chk("reset_mid_hold", DPBs | SCENs | MCENs | CCENs, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            step(4'b1111, 1'b0);
            chk("after_reset_scen", SCENs, (k == 6) ? 4'b1111 : 4'b0000);
        end
        idle(12);

        // ---- randomised run against the model ----
        b = 4'b0000;
        slow = 0;
        for (int k = 0; k < 3000; k++) begin
            if ((k % 200) == 0) slow = $urandom_range(0, 1);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, slow ? 29 : 5) == 0) b[i] = ~b[i];
            end
            step(b, $urandom_range(0, 399) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
